bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and transfer sequencer that shares the single `busctl` port among `NREQ` CPU domains. It sits between the domains and `busctl` in `soc`. Each domain raises a request with address, direction and write data. The arbiter picks a winner, drives `busctl` for one cycle, and returns the read data or write completion to that domain. An optional lock lets one domain issue back-to-back transfers without re-arbitrating.

## Interface
- `NREQ`, 2 — number of requesters; 1..8.
- `ADDR_W`, 17 — bus address width.
- `DATA_W`, 8 — bus data width.
- `MAX_HOLD`, 4 — maximum consecutive locked transfers; 1..15. Used only with lock compiled in.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `req`  in  NREQ  — per-requester transfer request.
- `we_in`  in  NREQ  — per-requester direction; 1 = write.
- `addr_in`  in  NREQ*ADDR_W  — requester i at `[i*ADDR_W +: ADDR_W]`.
- `wdata_in`  in  NREQ*DATA_W  — requester i at `[i*DATA_W +: DATA_W]`.
- `lock`  in  NREQ  — keep the grant for the next transfer. Present only when `BUS_ARB_LOCK_EN` is defined.
- `gnt`  out  NREQ  — one-hot; high for the winner during ISSUE.
- `done`  out  NREQ  — one-hot, one cycle; transfer complete (RESP state).
- `rdata`  out  DATA_W  — read data, valid while `done` is high on a read; shared by all requesters.
- `bus_we`  out  1  — to `busctl` `write_en`.
- `bus_addr`  out  ADDR_W  — to `busctl` `addr_in`.
- `bus_wdata`  out  DATA_W  — to `busctl` `data_in`.
- `bus_rdata`  in  DATA_W  — from `busctl` `data_out`; registered by `busctl`, valid one cycle after the address.

## Operation
- States: IDLE, ISSUE, RESP. Encoded in 2 bits; the unused encoding goes to IDLE.
- IDLE: if any `req` bit is set at the clock edge:
  - Select the winner by round-robin, starting the search at `ptr`.
  - Register the winner's `addr_in`, `we_in` and `wdata_in` onto the `bus_*` outputs.
  - Move to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (one cycle):
  - `gnt[w]`=1.
  - `bus_we` equals the latched direction.
  - `busctl` samples the address and write data at the end of this cycle.
  - Always move to RESP.
- RESP (one cycle):
  - `done[w]`=1 and `rdata`=`bus_rdata`. `rdata` is also driven on writes; its value is don't-care there.
  - `bus_we` is forced to 0.
  - Update `ptr` to (w+1) mod NREQ.
  - Next state is IDLE, unless the lock continuation below applies.
- Requesters hold `req`, `we_in`, `addr_in` and `wdata_in` stable from assertion until their `done`. They must deassert `req` in the cycle after `done` unless they want another transfer.
- `bus_addr` and `bus_wdata` keep their last values outside ISSUE. `bus_we` is high only in ISSUE.
- `NREQ`=1: the sole requester always wins and `ptr` stays 0.

## Timing
- Reset values: state=IDLE, `ptr`=0, and `gnt`, `done`, `rdata`, `bus_we`, `bus_addr`, `bus_wdata` all 0.
- Latency: `req` seen at edge T → `gnt` during cycle T+1 → `done` (and read data) during T+2.
- Unlocked throughput: one transfer per 3 cycles.
- Simultaneous requests resolve by `ptr`. After reset, requester 0 beats requester 1.
- A request dropped before the IDLE sample is ignored. Dropping `req` after grant does not abort the transfer.
- Reset mid-operation clears state immediately. An in-flight transfer is abandoned with no `done`. A write reaches `busctl` only if its ISSUE edge completed before reset asserted.

## Configuration
- `BUS_ARB_LOCK_EN` defined: the `lock` port exists.
  - In RESP, if `req[w]` and `lock[w]` are both high and `hold_cnt` < `MAX_HOLD`-1, the next state is ISSUE with the same winner. The new address, direction and data are sampled from requester w at the RESP edge.
  - `hold_cnt` increments on each such continuation.
  - `ptr` is not updated on a continuation.
  - `hold_cnt` clears on any return to IDLE and on reset.
  - Locked throughput: 2 cycles per transfer.
- Not defined: no `lock` port and no `hold_cnt`. RESP always goes to IDLE.

## Test plan
- Reset, then requester 0 reads 0x00010: `gnt`=01 at T+1, `bus_addr`=0x00010, `bus_we`=0; `done`=01 at T+2 with `rdata` equal to the `busctl` content.
- Requester 1 writes 0xA5 to 0x1FFFF, then reads it back: `bus_we`=1 for exactly one cycle; the readback `rdata`=0xA5.
- Both requesters hold `req` continuously for 6 transfers: grants alternate 0,1,0,1,0,1, with 3 cycles per transfer.
- `reset` asserted during ISSUE of a write: all outputs go to 0 immediately, no `done` is seen, and the first grant after release goes to requester 0.
- With `BUS_ARB_LOCK_EN` and `MAX_HOLD`=4: requester 0 holds `lock` while requester 1 requests. Requester 0 gets 4 transfers 2 cycles apart, then requester 1 is granted.
- Without `BUS_ARB_LOCK_EN`: the same stimulus minus `lock` yields strict alternation.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one busctl port among NREQ requesters, one transfer at a time.
// Define BUS_ARB_LOCK_EN to add the lock port for up to MAX_HOLD back-to-back transfers.
module bus_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we_in,
  input  logic [NREQ*ADDR_W-1:0]   addr_in,
  input  logic [NREQ*DATA_W-1:0]   wdata_in,
`ifdef BUS_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     bus_we,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_param_check
    $error("bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   w_q;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   ptr_inc;
  logic              win_valid;
  logic [NREQ-1:0]   sel_oh;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cont;

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // In IDLE the fresh winner is loaded; otherwise the current owner's inputs are used.
  assign sel_idx = (state_q == StIdle) ? win_idx : w_q;

  always_comb begin
    sel_oh    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IdxW'(i) == sel_idx) begin
        sel_oh[i] = 1'b1;
        sel_we    = we_in[i];
        sel_addr  = addr_in[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_inc = (32'(w_q) + 32'd1 >= NREQ) ? '0 : w_q + IdxW'(1);

  // busctl registers its read data, so it is valid exactly during RESP.
  assign rdata = (state_q == StResp) ? bus_rdata : '0;

`ifdef BUS_ARB_LOCK_EN
  localparam logic [3:0] HoldMax = 4'(MAX_HOLD - 1);
  logic [3:0] hold_q;

  assign cont = req[w_q] & lock[w_q] & (hold_q < HoldMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (state_q == StResp) begin
      hold_q <= cont ? hold_q + 4'd1 : '0;
    end else if (state_q == StIdle) begin
      hold_q <= '0;
    end
  end
`else
  assign cont = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      w_q       <= '0;
      gnt       <= '0;
      done      <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q   <= StIssue;
            w_q       <= win_idx;
            gnt       <= sel_oh;
            bus_we    <= sel_we;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
          end
        end
        StIssue: begin
          state_q <= StResp;
          gnt     <= '0;
          bus_we  <= 1'b0;
          done    <= sel_oh;
        end
        StResp: begin
          done <= '0;
          if (cont) begin
            state_q   <= StIssue;
            gnt       <= sel_oh;
            bus_we    <= sel_we;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
          end else begin
            state_q <= StIdle;
            ptr_q   <= ptr_inc;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          done    <= '0;
          bus_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small busctl memory model on the bus side.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we_in;
  logic [33:0] addr_in;
  logic [15:0] wdata_in;
`ifdef BUS_ARB_LOCK_EN
  logic [1:0]  lock;
`endif
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        bus_we;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem [0:131071];

  bus_arbiter #(
    .NREQ    (2),
    .ADDR_W  (17),
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we_in    (we_in),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
`ifdef BUS_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .done     (done),
    .rdata    (rdata),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // busctl: synchronous write, registered read of the presented address.
  always @(posedge clk) begin
    if (bus_we) mem[bus_addr] <= bus_wdata;
    bus_rdata <= mem[bus_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [16:0] a1,
                       input logic [16:0] a0, input logic [7:0] d1, input logic [7:0] d0);
    req      = r;
    we_in    = w;
    addr_in  = {a1, a0};
    wdata_in = {d1, d0};
  endtask

  initial begin
    // Memory preload: mem[a] = a[7:0] ^ 8'h3C.
    for (int i = 0; i < 131072; i++) mem[i] = 8'(i) ^ 8'h3C;
    reset = 1'b0;
`ifdef BUS_ARB_LOCK_EN
    lock = 2'b00;
`endif
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    reset = 1'b1;
    step();
    check("idle_gnt", gnt, 0);

    // Requester 0 reads 0x00010.
    drive(2'b01, 2'b00, '0, 17'h00010, '0, '0);
    step();
    check("rd0_gnt", gnt, 1);
    check("rd0_addr", bus_addr, 17'h00010);
    check("rd0_we", bus_we, 0);
    check("rd0_done_early", done, 0);
    step();
    check("rd0_done", done, 1);
    check("rd0_gnt_off", gnt, 0);
    check("rd0_rdata", rdata, 8'h2C);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();
    check("rd0_idle_done", done, 0);

    // Requester 1 writes 0xA5 to 0x1FFFF, then reads it back.
    drive(2'b10, 2'b10, 17'h1FFFF, '0, 8'hA5, '0);
    step();
    check("wr1_gnt", gnt, 2);
    check("wr1_we", bus_we, 1);
    check("wr1_addr", bus_addr, 17'h1FFFF);
    check("wr1_wdata", bus_wdata, 8'hA5);
    step();
    check("wr1_done", done, 2);
    check("wr1_we_resp", bus_we, 0);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();
    check("wr1_we_idle", bus_we, 0);
    check("wr1_wdata_hold", bus_wdata, 8'hA5);
    drive(2'b10, 2'b00, 17'h1FFFF, '0, '0, '0);
    step();
    check("rb1_gnt", gnt, 2);
    check("rb1_we", bus_we, 0);
    step();
    check("rb1_done", done, 2);
    check("rb1_rdata", rdata, 8'hA5);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();

    // Both hold req: grants alternate 0,1,... with 3 cycles per transfer.
    drive(2'b11, 2'b00, 17'h00031, 17'h00020, '0, '0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_gnt", gnt, (k % 2 == 1) ? 2 : 1);
      step();
      check("rr_done", done, (k % 2 == 1) ? 2 : 1);
      check("rr_rdata", rdata, (k % 2 == 1) ? 8'h0D : 8'h1C);
      step();
      check("rr_gap_gnt", gnt, 0);
      check("rr_gap_done", done, 0);
    end
    drive(2'b00, 2'b00, '0, '0, '0, '0);

    // Requester 0 write/readback leaves ptr pointing at requester 1.
    drive(2'b01, 2'b01, '0, 17'h00040, '0, 8'h5A);
    step();
    check("wr0_gnt", gnt, 1);
    check("wr0_we", bus_we, 1);
    step();
    check("wr0_done", done, 1);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();
    drive(2'b01, 2'b00, '0, 17'h00040, '0, '0);
    step();
    check("rb0_gnt", gnt, 1);
    step();
    check("rb0_rdata", rdata, 8'h5A);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();

    // Reset during ISSUE of a write by requester 1.
    drive(2'b10, 2'b10, 17'h00050, '0, 8'h77, '0);
    step();
    check("rw_gnt", gnt, 2);
    check("rw_we", bus_we, 1);
    reset = 1'b0;
    #1;
    check("rw_async_gnt", gnt, 0);
    check("rw_async_we", bus_we, 0);
    check("rw_async_addr", bus_addr, 0);
    check("rw_async_wdata", bus_wdata, 0);
    check("rw_async_done", done, 0);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();
    check("rw_no_done", done, 0);
    check("rw_mem_untouched", mem[17'h00050], 8'h6C);
    reset = 1'b1;
    drive(2'b11, 2'b00, 17'h00031, 17'h00020, '0, '0);
    step();
    check("post_rst_gnt", gnt, 1);
    step();
    check("post_rst_done", done, 1);
    check("post_rst_rdata", rdata, 8'h1C);
    step();
    step();
    check("post_rst_gnt2", gnt, 2);
    step();
    check("post_rst_done2", done, 2);
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();

`ifdef BUS_ARB_LOCK_EN
    // Requester 0 locks: 4 transfers 2 cycles apart, then requester 1.
    drive(2'b11, 2'b00, 17'h00031, 17'h00020, '0, '0);
    lock = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      check("lk_gnt", gnt, 1);
      step();
      check("lk_done", done, 1);
      check("lk_rdata", rdata, 8'h1C);
    end
    step();
    check("lk_release_gnt", gnt, 0);
    step();
    check("lk_next_gnt", gnt, 2);
    lock = 2'b00;
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();
    check("lk_next_done", done, 2);
    step();
`else
    // Same stimulus without lock: strict alternation.
    drive(2'b11, 2'b00, 17'h00031, 17'h00020, '0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("nl_gnt", gnt, (k % 2 == 1) ? 2 : 1);
      step();
      check("nl_done", done, (k % 2 == 1) ? 2 : 1);
      step();
      check("nl_gap_gnt", gnt, 0);
    end
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
